// File: rtl/int_issue_queue.sv
// Integer issue queue: age-ordered collapsing queue of ALU instructions with
// CDB operand wakeup and oldest-ready-first selection.
module int_issue_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       dispatch_en,
  input  logic [3:0]                 dispatch_op,
  input  logic [TAG_W-1:0]           dispatch_rd_tag,
  input  logic                       dispatch_rs1_valid,
  input  logic [TAG_W-1:0]           dispatch_rs1_tag,
  input  logic [DATA_W-1:0]          dispatch_rs1_data,
  input  logic                       dispatch_rs2_valid,
  input  logic [TAG_W-1:0]           dispatch_rs2_tag,
  input  logic [DATA_W-1:0]          dispatch_rs2_data,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  input  logic                       issue_int,
  output logic                       ready_int,
  output logic [3:0]                 issue_op,
  output logic [DATA_W-1:0]          issue_rs1_data,
  output logic [DATA_W-1:0]          issue_rs2_data,
  output logic [TAG_W-1:0]           issue_rd_tag,
  output logic                       queue_full,
  output logic [$clog2(DEPTH):0]     queue_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  rs1v_q, rs1v_d;
  logic [DEPTH-1:0]  rs2v_q, rs2v_d;
  logic [3:0]        op_q       [DEPTH];
  logic [3:0]        op_d       [DEPTH];
  logic [TAG_W-1:0]  rd_q       [DEPTH];
  logic [TAG_W-1:0]  rd_d       [DEPTH];
  logic [TAG_W-1:0]  rs1_tag_q  [DEPTH];
  logic [TAG_W-1:0]  rs1_tag_d  [DEPTH];
  logic [TAG_W-1:0]  rs2_tag_q  [DEPTH];
  logic [TAG_W-1:0]  rs2_tag_d  [DEPTH];
  logic [DATA_W-1:0] rs1_data_q [DEPTH];
  logic [DATA_W-1:0] rs1_data_d [DEPTH];
  logic [DATA_W-1:0] rs2_data_q [DEPTH];
  logic [DATA_W-1:0] rs2_data_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  count_after;

  logic [DEPTH-1:0]  rdy;
  logic [IDX_W-1:0]  sel;
  logic              found;
  logic              do_issue;
  logic              do_disp;

  // Oldest ready entry: lowest index with both operands present.
  always_comb begin
    rdy   = valid_q & rs1v_q & rs2v_q;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i] && !found) begin
        sel   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  assign ready_int      = |rdy;
  assign issue_op       = op_q[sel];
  assign issue_rs1_data = rs1_data_q[sel];
  assign issue_rs2_data = rs2_data_q[sel];
  assign issue_rd_tag   = rd_q[sel];
  assign queue_count    = count_q;
  assign queue_full     = (count_q == CNT_W'(DEPTH));

  assign do_issue    = issue_int & ready_int;
  assign do_disp     = dispatch_en & ~queue_full;
  assign count_after = count_q - CNT_W'(do_issue);

  // Next state: collapse on issue, append dispatch, then wake up in place.
  always_comb begin
    valid_d = valid_q;
    rs1v_d  = rs1v_q;
    rs2v_d  = rs2v_q;
    count_d = count_after + CNT_W'(do_disp);
    for (int i = 0; i < DEPTH; i++) begin
      op_d[i]       = op_q[i];
      rd_d[i]       = rd_q[i];
      rs1_tag_d[i]  = rs1_tag_q[i];
      rs2_tag_d[i]  = rs2_tag_q[i];
      rs1_data_d[i] = rs1_data_q[i];
      rs2_data_d[i] = rs2_data_q[i];
    end

    if (do_issue) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(sel)) begin
          valid_d[i]    = valid_q[i+1];
          rs1v_d[i]     = rs1v_q[i+1];
          rs2v_d[i]     = rs2v_q[i+1];
          op_d[i]       = op_q[i+1];
          rd_d[i]       = rd_q[i+1];
          rs1_tag_d[i]  = rs1_tag_q[i+1];
          rs2_tag_d[i]  = rs2_tag_q[i+1];
          rs1_data_d[i] = rs1_data_q[i+1];
          rs2_data_d[i] = rs2_data_q[i+1];
        end
      end
      // The top slot always vacates: it either shifted down or was selected.
      valid_d[DEPTH-1] = 1'b0;
      rs1v_d[DEPTH-1]  = 1'b0;
      rs2v_d[DEPTH-1]  = 1'b0;
    end

    if (do_disp) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == count_after) begin
          valid_d[i]    = 1'b1;
          op_d[i]       = dispatch_op;
          rd_d[i]       = dispatch_rd_tag;
          rs1v_d[i]     = dispatch_rs1_valid;
          rs1_tag_d[i]  = dispatch_rs1_tag;
          rs1_data_d[i] = dispatch_rs1_data;
          rs2v_d[i]     = dispatch_rs2_valid;
          rs2_tag_d[i]  = dispatch_rs2_tag;
          rs2_data_d[i] = dispatch_rs2_data;
        end
      end
    end

    // Wakeup sees post-shift positions, including a same-cycle dispatch.
    if (cdb_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_d[i] && !rs1v_d[i] && (rs1_tag_d[i] == cdb_tag)) begin
          rs1v_d[i]     = 1'b1;
          rs1_data_d[i] = cdb_data;
        end
        if (valid_d[i] && !rs2v_d[i] && (rs2_tag_d[i] == cdb_tag)) begin
          rs2v_d[i]     = 1'b1;
          rs2_data_d[i] = cdb_data;
        end
      end
    end

    if (flush) begin
      valid_d = '0;
      rs1v_d  = '0;
      rs2v_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      rs1v_q  <= '0;
      rs2v_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]       <= '0;
        rd_q[i]       <= '0;
        rs1_tag_q[i]  <= '0;
        rs2_tag_q[i]  <= '0;
        rs1_data_q[i] <= '0;
        rs2_data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rs1v_q  <= rs1v_d;
      rs2v_q  <= rs2v_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]       <= op_d[i];
        rd_q[i]       <= rd_d[i];
        rs1_tag_q[i]  <= rs1_tag_d[i];
        rs2_tag_q[i]  <= rs2_tag_d[i];
        rs1_data_q[i] <= rs1_data_d[i];
        rs2_data_q[i] <= rs2_data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue: dispatch/issue, CDB wakeup, full-drop,
// age-ordered selection, dispatch-time capture, async reset and flush.
module tb_int_issue_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              dispatch_en;
  logic [3:0]        dispatch_op;
  logic [TAG_W-1:0]  dispatch_rd_tag;
  logic              dispatch_rs1_valid;
  logic [TAG_W-1:0]  dispatch_rs1_tag;
  logic [DATA_W-1:0] dispatch_rs1_data;
  logic              dispatch_rs2_valid;
  logic [TAG_W-1:0]  dispatch_rs2_tag;
  logic [DATA_W-1:0] dispatch_rs2_data;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              issue_int;
  logic              ready_int;
  logic [3:0]        issue_op;
  logic [DATA_W-1:0] issue_rs1_data;
  logic [DATA_W-1:0] issue_rs2_data;
  logic [TAG_W-1:0]  issue_rd_tag;
  logic              queue_full;
  logic [$clog2(DEPTH):0] queue_count;

  int checks   = 0;
  int failures = 0;

  int_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_en(dispatch_en), .dispatch_op(dispatch_op), .dispatch_rd_tag(dispatch_rd_tag),
    .dispatch_rs1_valid(dispatch_rs1_valid), .dispatch_rs1_tag(dispatch_rs1_tag),
    .dispatch_rs1_data(dispatch_rs1_data),
    .dispatch_rs2_valid(dispatch_rs2_valid), .dispatch_rs2_tag(dispatch_rs2_tag),
    .dispatch_rs2_data(dispatch_rs2_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_int(issue_int), .ready_int(ready_int), .issue_op(issue_op),
    .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
    .issue_rd_tag(issue_rd_tag), .queue_full(queue_full), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush       = 1'b0;
    dispatch_en = 1'b0;
    cdb_valid   = 1'b0;
    issue_int   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic disp(input logic [3:0] op, input logic [TAG_W-1:0] rd,
                      input logic v1, input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] d1,
                      input logic v2, input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] d2);
    dispatch_en        = 1'b1;
    dispatch_op        = op;
    dispatch_rd_tag    = rd;
    dispatch_rs1_valid = v1;
    dispatch_rs1_tag   = t1;
    dispatch_rs1_data  = d1;
    dispatch_rs2_valid = v2;
    dispatch_rs2_tag   = t2;
    dispatch_rs2_data  = d2;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_data  = d;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    disp(4'd0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    dispatch_en = 1'b0;
    cdb_tag  = '0;
    cdb_data = '0;
    #12;
    chk("reset_count", 32'(queue_count), 32'd0);
    chk("reset_full", 32'(queue_full), 32'd0);
    chk("reset_ready", 32'(ready_int), 32'd0);
    rst = 1'b1;

    // Single ready instruction issues with its operands.
    disp(4'd3, 6'd5, 1'b1, 6'd0, 32'd10, 1'b1, 6'd0, 32'd20);
    step();
    chk("t1_count", 32'(queue_count), 32'd1);
    chk("t1_ready", 32'(ready_int), 32'd1);
    chk("t1_op", 32'(issue_op), 32'd3);
    chk("t1_rs1", issue_rs1_data, 32'd10);
    chk("t1_rs2", issue_rs2_data, 32'd20);
    chk("t1_rd", 32'(issue_rd_tag), 32'd5);
    issue_int = 1'b1;
    step();
    chk("t1_count_after", 32'(queue_count), 32'd0);
    chk("t1_ready_after", 32'(ready_int), 32'd0);

    // CDB wakeup is not visible on ready_int until the next cycle.
    disp(4'd1, 6'd6, 1'b1, 6'd0, 32'd7, 1'b0, 6'd9, 32'd0);
    step();
    chk("t2_wait_ready", 32'(ready_int), 32'd0);
    cdb(6'd9, 32'h55);
    #1;
    chk("t2_same_cycle_ready", 32'(ready_int), 32'd0);
    step();
    chk("t2_woken_ready", 32'(ready_int), 32'd1);
    chk("t2_rs2", issue_rs2_data, 32'h55);
    chk("t2_rs1", issue_rs1_data, 32'd7);
    issue_int = 1'b1;
    step();
    chk("t2_count", 32'(queue_count), 32'd0);

    // Fill, then dispatch+issue together: dispatch is dropped.
    for (int i = 0; i < 4; i++) begin
      disp(4'd2, TAG_W'(10 + i), 1'b1, '0, 32'(100 + i), 1'b1, '0, 32'd1);
      step();
    end
    chk("t3_full", 32'(queue_full), 32'd1);
    chk("t3_count4", 32'(queue_count), 32'd4);
    disp(4'd2, 6'd20, 1'b1, '0, 32'd0, 1'b1, '0, 32'd0);
    issue_int = 1'b1;
    step();
    chk("t3_count3", 32'(queue_count), 32'd3);
    chk("t3_not_full", 32'(queue_full), 32'd0);
    chk("t3_rd11", 32'(issue_rd_tag), 32'd11);
    issue_int = 1'b1;
    step();
    chk("t3_rd12", 32'(issue_rd_tag), 32'd12);
    issue_int = 1'b1;
    step();
    chk("t3_rd13", 32'(issue_rd_tag), 32'd13);
    chk("t3_rs1_13", issue_rs1_data, 32'd103);
    issue_int = 1'b1;
    step();
    chk("t3_drained", 32'(queue_count), 32'd0);
    chk("t3_drained_ready", 32'(ready_int), 32'd0);

    // Oldest ready wins; younger entries collapse down after issue.
    disp(4'd4, 6'd2, 1'b0, 6'd30, 32'd0, 1'b1, '0, 32'd3);
    step();
    disp(4'd5, 6'd7, 1'b1, '0, 32'd70, 1'b1, '0, 32'd71);
    step();
    disp(4'd6, 6'd8, 1'b1, '0, 32'd80, 1'b1, '0, 32'd81);
    step();
    chk("t4_count3", 32'(queue_count), 32'd3);
    chk("t4_rd7", 32'(issue_rd_tag), 32'd7);
    issue_int = 1'b1;
    step();
    chk("t4_rd8", 32'(issue_rd_tag), 32'd8);
    chk("t4_op6", 32'(issue_op), 32'd6);
    chk("t4_count2", 32'(queue_count), 32'd2);
    issue_int = 1'b1;
    step();
    chk("t4_count1", 32'(queue_count), 32'd1);
    chk("t4_blocked", 32'(ready_int), 32'd0);
    issue_int = 1'b1;
    step();
    chk("t4_ignored_issue", 32'(queue_count), 32'd1);
    cdb(6'd30, 32'h99);
    step();
    chk("t4_wake_ready", 32'(ready_int), 32'd1);
    chk("t4_wake_rs1", issue_rs1_data, 32'h99);
    chk("t4_wake_rd", 32'(issue_rd_tag), 32'd2);

    // Wakeup coinciding with issue reaches the shifted entry.
    disp(4'd7, 6'd3, 1'b1, '0, 32'd33, 1'b0, 6'd40, 32'd0);
    step();
    chk("t5_count2", 32'(queue_count), 32'd2);
    issue_int = 1'b1;
    cdb(6'd40, 32'h77);
    step();
    chk("t5_count1", 32'(queue_count), 32'd1);
    chk("t5_ready", 32'(ready_int), 32'd1);
    chk("t5_rd", 32'(issue_rd_tag), 32'd3);
    chk("t5_rs2", issue_rs2_data, 32'h77);
    issue_int = 1'b1;
    step();
    chk("t5_count0", 32'(queue_count), 32'd0);

    // Dispatch-time capture from a matching CDB broadcast.
    disp(4'd8, 6'd4, 1'b0, 6'd4, 32'd0, 1'b1, '0, 32'h11);
    cdb(6'd4, 32'hAA);
    step();
    chk("t6_ready", 32'(ready_int), 32'd1);
    chk("t6_rs1", issue_rs1_data, 32'hAA);
    chk("t6_rs2", issue_rs2_data, 32'h11);
    issue_int = 1'b1;
    step();
    chk("t6_count0", 32'(queue_count), 32'd0);

    // Asynchronous reset mid-cycle discards everything immediately.
    for (int i = 0; i < 3; i++) begin
      disp(4'd9, TAG_W'(50 + i), 1'b1, '0, 32'd1, 1'b1, '0, 32'd2);
      step();
    end
    chk("t7_count3", 32'(queue_count), 32'd3);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t7_rst_count", 32'(queue_count), 32'd0);
    chk("t7_rst_ready", 32'(ready_int), 32'd0);
    chk("t7_rst_full", 32'(queue_full), 32'd0);
    rst = 1'b1;
    step();
    chk("t7_post_rst_count", 32'(queue_count), 32'd0);

    // Flush beats dispatch and issue in the same cycle.
    disp(4'd1, 6'd60, 1'b1, '0, 32'd1, 1'b1, '0, 32'd1);
    step();
    disp(4'd1, 6'd61, 1'b1, '0, 32'd1, 1'b1, '0, 32'd1);
    step();
    chk("t8_count2", 32'(queue_count), 32'd2);
    disp(4'd1, 6'd62, 1'b1, '0, 32'd1, 1'b1, '0, 32'd1);
    issue_int = 1'b1;
    flush     = 1'b1;
    step();
    chk("t8_flush_count", 32'(queue_count), 32'd0);
    chk("t8_flush_ready", 32'(ready_int), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
